// File: rtl/spi_master_ctrl.sv
// Host-side SPI master: serialises {cmd, payload} MSB-first at one bit per clk
// and, for read-data commands, shifts the returned byte in from MISO.
module spi_master_ctrl #(
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned GAP       = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           cmd,
  input  logic [ADDR_SIZE-1:0] tx_byte,
  output logic                 ready,
  output logic                 done,
  output logic [ADDR_SIZE-1:0] rx_byte,
  output logic                 rx_valid,
  output logic                 SS_n,
  output logic                 MOSI,
  input  logic                 MISO
);

  localparam int unsigned FL   = ADDR_SIZE + 2;
  localparam int unsigned M1   = (FL > RD_LAT) ? FL : RD_LAT;
  localparam int unsigned MAXC = (M1 > GAP) ? M1 : GAP;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    IDLE, SELECT, CMD, SHIFT, WAIT, READ, DESELECT
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [FL-1:0]        sh_q;
  logic                 rd_q;
  logic [ADDR_SIZE-2:0] rxsh_q;
  logic [ADDR_SIZE-1:0] rx_next;
  logic                 ss_n_d, mosi_d;

  assign rx_next = {rxsh_q, MISO};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      rd_q     <= 1'b0;
      rxsh_q   <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      SS_n     <= 1'b1;
      MOSI     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      SS_n     <= ss_n_d;
      MOSI     <= mosi_d;
      rx_valid <= 1'b0;
      if (state_q == IDLE && start) begin
        sh_q <= {cmd, tx_byte};
        rd_q <= (cmd == 2'b11);
      end else if (state_d == SHIFT) begin
        sh_q <= {sh_q[FL-2:0], 1'b0};
      end
      if (state_q == READ) begin
        rxsh_q <= rx_next[ADDR_SIZE-2:0];
        if (cnt_q == '0) begin
          rx_byte  <= rx_next;
          rx_valid <= 1'b1;
        end
      end
    end
  end

  // Each state's length is loaded into cnt on entry; the counter holds at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : '0;
    case (state_q)
      IDLE:     if (start) state_d = SELECT;
      SELECT:   state_d = CMD;
      CMD: begin
        state_d = SHIFT;
        cnt_d   = CW'(FL - 1);
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          if (!rd_q) begin
            state_d = DESELECT;
            cnt_d   = CW'(GAP - 1);
          end else if (RD_LAT == 0) begin
            state_d = READ;
            cnt_d   = CW'(ADDR_SIZE - 1);
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(RD_LAT - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = READ;
          cnt_d   = CW'(ADDR_SIZE - 1);
        end
      end
      READ: begin
        if (cnt_q == '0) begin
          state_d = DESELECT;
          cnt_d   = CW'(GAP - 1);
        end
      end
      DESELECT: if (cnt_q == '0) state_d = IDLE;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // SS_n/MOSI are registered from the next state so they line up with it.
  always_comb begin
    ready  = (state_q == IDLE);
    done   = (state_q == DESELECT) && (cnt_q == '0);
    ss_n_d = 1'b1;
    mosi_d = 1'b0;
    case (state_d)
      SELECT: begin
        ss_n_d = 1'b0;
        mosi_d = cmd[1];
      end
      CMD, SHIFT: begin
        ss_n_d = 1'b0;
        mosi_d = sh_q[FL-1];
      end
      WAIT, READ: ss_n_d = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: a behavioural SPI slave + RAM answers
// reads; a reference RAM model predicts every frame and returned byte.
module tb_spi_master_ctrl;

  localparam int unsigned AW     = 8;
  localparam int unsigned RD_LAT = 1;
  localparam int unsigned GAP    = 1;
  localparam int unsigned FL     = AW + 2;

  logic          clk, rst, start, ready, done, rx_valid, SS_n, MOSI, MISO;
  logic [1:0]    cmd;
  logic [AW-1:0] tx_byte, rx_byte;

  spi_master_ctrl #(.ADDR_SIZE(AW), .RD_LAT(RD_LAT), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd(cmd), .tx_byte(tx_byte),
    .ready(ready), .done(done), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    c;
    logic [AW-1:0] b;
  } txn_t;

  txn_t          exp_q[$];
  logic [AW-1:0] rx_q[$];
  int            compared = 0;
  int            mismatched = 0;
  int            exp_done = 0;
  int            n_done = 0;

  logic [AW-1:0] ref_mem[256];
  logic [AW-1:0] r_waddr = '0, r_raddr = '0;
  logic [AW-1:0] slave_mem[256];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_len(input logic [1:0] c);
    return (c == 2'b11) ? int'(FL + 2 + RD_LAT + AW) : int'(FL + 2);
  endfunction

  // Select and cmd cycles both repeat the frame MSB, then the frame MSB-first, then zeros.
  function automatic logic exp_bit(input logic [FL-1:0] f, input int i);
    if (i < 2) return f[FL-1];
    if (i < int'(FL + 2)) return f[FL+1-i];
    return 1'b0;
  endfunction

  // Behavioural slave: decodes the frame after its last bit, drives MISO in the read window.
  int            s_k = 0;
  logic [FL-1:0] s_f = '0;
  logic [1:0]    s_cmd = '0;
  logic [AW-1:0] s_waddr = '0, s_raddr = '0;
  initial MISO = 1'b0;
  always @(negedge clk) begin
    logic [AW-1:0] v;
    int j;
    if (SS_n) begin
      s_k = 0;
      s_cmd = 2'b00;
      MISO = 1'b0;
    end else begin
      if (s_k >= 2 && s_k < int'(FL + 2)) s_f = {s_f[FL-2:0], MOSI};
      if (s_k == int'(FL + 1)) begin
        s_cmd = s_f[FL-1:FL-2];
        case (s_cmd)
          2'b00: s_waddr = s_f[AW-1:0];
          2'b01: slave_mem[s_waddr] = s_f[AW-1:0];
          2'b10: s_raddr = s_f[AW-1:0];
          default: ;
        endcase
      end
      j = s_k - int'(FL + 2 + RD_LAT);
      if (s_cmd == 2'b11 && j >= 0 && j < int'(AW)) begin
        v = slave_mem[s_raddr];
        MISO = v[AW-1-j];
      end else begin
        MISO = 1'b0;
      end
      s_k++;
    end
  end

  // Monitor: collects each SS_n-low window and checks it against the scoreboard.
  logic          mbits[$];
  int            hi_cnt = 0;
  logic          seen_frame = 1'b0;
  logic [AW-1:0] model_rx = '0;
  always @(negedge clk) begin
    txn_t t;
    logic [31:0] gv, ev;
    logic [AW-1:0] e;
    int n;
    if (rst) begin
      mbits.delete();
      hi_cnt = 0;
      seen_frame = 1'b0;
      model_rx = '0;
    end else begin
      if (!SS_n) begin
        if (hi_cnt > 0 && seen_frame) chk("gap_min", 32'(hi_cnt >= int'(GAP)), 32'd1);
        seen_frame = 1'b1;
        hi_cnt = 0;
        mbits.push_back(MOSI);
        chk("ready_busy", 32'(ready), 32'd0);
      end else begin
        hi_cnt++;
        chk("mosi_idle", 32'(MOSI), 32'd0);
        if (mbits.size() > 0) begin
          if (exp_q.size() == 0) begin
            chk("frame_expected", exp_q.size(), 32'd1);
          end else begin
            t = exp_q.pop_front();
            n = exp_len(t.c);
            chk("frame_len", mbits.size(), n);
            gv = '0;
            ev = '0;
            foreach (mbits[i]) gv = {gv[30:0], mbits[i]};
            for (int i = 0; i < n; i++) ev = {ev[30:0], exp_bit({t.c, t.b}, i)};
            chk("frame_bits", gv, ev);
          end
          mbits.delete();
        end
      end
      if (done) begin
        chk("done_pos", hi_cnt, GAP);
        n_done++;
      end
      if (rx_valid) begin
        chk("rxv_pos", hi_cnt, 32'd1);
        if (rx_q.size() == 0) begin
          chk("rx_expected", rx_q.size(), 32'd1);
        end else begin
          e = rx_q.pop_front();
          chk("rx_byte", rx_byte, e);
          model_rx = e;
        end
      end else begin
        chk("rx_hold", rx_byte, model_rx);
      end
    end
  end

  task automatic issue(input logic [1:0] c, input logic [AW-1:0] b, input bit hold);
    int n = 0;
    while (!ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready) begin
      chk("ready_wait", 32'(ready), 32'd1);
      return;
    end
    start = 1'b1;
    cmd = c;
    tx_byte = b;
    exp_q.push_back('{c: c, b: b});
    case (c)
      2'b00: r_waddr = b;
      2'b01: ref_mem[r_waddr] = b;
      2'b10: r_raddr = b;
      default: rx_q.push_back(ref_mem[r_raddr]);
    endcase
    exp_done++;
    @(posedge clk); #1;
    if (!hold) begin
      start = 1'b0;
      cmd = 2'($urandom);
      tx_byte = AW'($urandom);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(ready && exp_q.size() == 0) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_wait", 32'(ready && exp_q.size() == 0), 32'd1);
  endtask

  initial begin
    logic [AW-1:0] v;
    logic [1:0] c;
    int d0;
    rst = 1'b1;
    start = 1'b0;
    cmd = 2'b00;
    tx_byte = '0;
    for (int i = 0; i < 256; i++) begin
      v = AW'($urandom);
      slave_mem[i] = v;
      ref_mem[i] = v;
    end
    slave_mem[255] = 8'hA3;
    ref_mem[255] = 8'hA3;

    @(posedge clk); #1;
    chk("rst_ss_n", 32'(SS_n), 32'd1);
    chk("rst_mosi", 32'(MOSI), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_byte", rx_byte, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    issue(2'b00, 8'h07, 0);
    issue(2'b01, 8'h55, 0);
    wait_idle();
    chk("slave_ram07", slave_mem[7], 32'h55);
    issue(2'b10, 8'h07, 0);
    issue(2'b11, AW'($urandom), 0);
    issue(2'b00, 8'hFF, 0);
    issue(2'b10, 8'hFF, 0);
    issue(2'b11, AW'($urandom), 0);
    issue(2'b00, 8'h12, 0);
    wait_idle();

    // Abort a write-addr at shift bit 5; nothing is expected from it.
    start = 1'b1;
    cmd = 2'b00;
    tx_byte = 8'h3C;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    chk("abort_busy", 32'(SS_n), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_ss_n", 32'(SS_n), 32'd1);
    chk("abort_mosi", 32'(MOSI), 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_rx_valid", 32'(rx_valid), 32'd0);
    rst = 1'b0;
    issue(2'b00, 8'h03, 0);
    issue(2'b01, 8'h9E, 0);
    issue(2'b10, 8'h03, 0);
    issue(2'b11, AW'($urandom), 0);
    wait_idle();

    d0 = n_done;
    issue(2'b00, 8'h05, 0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    start = 1'b1;
    cmd = 2'b11;
    tx_byte = 8'hAA;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    chk("ignored_one_done", n_done - d0, 32'd1);

    for (int i = 0; i < 4; i++) issue(2'(i), AW'($urandom_range(0, 7)), 1);
    start = 1'b0;
    wait_idle();

    for (int i = 0; i < 80; i++) begin
      c = 2'($urandom);
      v = (c == 2'b00 || c == 2'b10) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      issue(c, v, bit'($urandom_range(0, 1)));
    end
    start = 1'b0;
    wait_idle();
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("done_count", n_done, exp_done);
    chk("rx_pending", rx_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
